// File: rtl/midori64_masked_sequencer.sv
// Front-end sequencer for the masked Midori64 core: operand load,
// round-controller release, done-latency capture and result hand-off.
module midori64_masked_sequencer #(
  parameter int SHARES       = 3,
  parameter int SBOX_STAGES  = 3,
  parameter int DONE_LATENCY = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [64*SHARES-1:0]    pt_shares,
  input  logic [128*SHARES-1:0]   key_shares,
  output logic                    core_start,
  output logic [64*SHARES-1:0]    core_pt,
  output logic [128*SHARES-1:0]   core_key,
  input  logic                    core_done,
  input  logic [64*SHARES-1:0]    core_ct,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [64*SHARES-1:0]    ct_shares,
  output logic                    busy,
  output logic                    err
);

  localparam int PW = 64 * SHARES;
  localparam int KW = 128 * SHARES;
  localparam int CW = 10;
  localparam logic [CW-1:0] DL  = 10'(DONE_LATENCY);
  localparam logic [CW-1:0] TMO = 10'(TIMEOUT);

  // A run that cannot finish before the abort limit is a build error.
  if (TIMEOUT > 1023 || TIMEOUT < 1 || DONE_LATENCY < 1 ||
      15 * SBOX_STAGES + DONE_LATENCY > TIMEOUT) begin : g_cfg_bad
    $error("midori64_masked_sequencer: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_OUT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_pt;
  logic [KW-1:0]   r_key;
  logic [PW-1:0]   r_ct;
  logic            r_err;
  logic [CW-1:0]   r_cyc_cnt;
  logic [CW-1:0]   r_done_cnt;

  logic            w_accept;
  logic            w_capture;
  logic            w_timeout;
  logic [CW-1:0]   w_cyc_inc;
  logic [CW-1:0]   w_done_inc;
  logic [CW-1:0]   w_cyc_nxt;
  logic [CW-1:0]   w_done_nxt;
  logic            w_err_nxt;

  assign w_accept = (r_state == S_IDLE) && in_valid;

  assign w_cyc_inc  = (r_cyc_cnt == '1) ? r_cyc_cnt
                                        : r_cyc_cnt + 1'b1;
  assign w_done_inc = (r_done_cnt == '1) ? r_done_cnt
                                         : r_done_cnt + 1'b1;

  assign w_capture = (r_state == S_RUN) && core_done &&
                     (w_done_inc >= DL);
  assign w_timeout = (r_state == S_RUN) && (w_cyc_inc >= TMO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_capture) begin
          w_state_nxt = S_OUT;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OUT: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b1;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_LOAD: busy = 1'b1;
      S_RUN: begin
        core_start = 1'b0;
        busy       = 1'b1;
      end
      S_OUT: out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_cyc_nxt  = r_cyc_cnt;
    w_done_nxt = r_done_cnt;
    if (r_state == S_LOAD) begin
      w_cyc_nxt  = '0;
      w_done_nxt = '0;
    end else if (r_state == S_RUN) begin
      w_cyc_nxt  = w_cyc_inc;
      w_done_nxt = core_done ? w_done_inc : '0;
    end
  end

  // Capture wins over an abort landing on the same cycle.
  always_comb begin
    w_err_nxt = r_err;
    if (w_accept) begin
      w_err_nxt = 1'b0;
    end else if (w_timeout && !w_capture) begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pt       <= '0;
      r_key      <= '0;
      r_ct       <= '0;
      r_err      <= 1'b0;
      r_cyc_cnt  <= '0;
      r_done_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_pt  <= pt_shares;
        r_key <= key_shares;
      end
      if (w_capture) begin
        r_ct <= core_ct;
      end
      r_err      <= w_err_nxt;
      r_cyc_cnt  <= w_cyc_nxt;
      r_done_cnt <= w_done_nxt;
    end
  end

  assign core_pt   = r_pt;
  assign core_key  = r_key;
  assign ct_shares = r_ct;
  assign err       = r_err;

endmodule

// File: tb/tb_midori64_masked_sequencer.sv
// Bench for midori64_masked_sequencer with a behavioural core stub
// whose per-share output recombines to the Midori64 all-zero answer.
module tb_midori64_masked_sequencer;

  localparam int SH  = 3;
  localparam int PW  = 64 * SH;
  localparam int KW  = 128 * SH;
  localparam int LAT = 49;
  localparam int TMO = 100;
  localparam logic [63:0] KAT = 64'h3c9cceda2bbd449a;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] pt_shares;
  logic [KW-1:0] key_shares;
  logic          core_start;
  logic [PW-1:0] core_pt;
  logic [KW-1:0] core_key;
  logic          core_done;
  logic [PW-1:0] core_ct;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] ct_shares;
  logic          busy;
  logic          err;

  midori64_masked_sequencer #(
    .SHARES(SH),
    .SBOX_STAGES(3),
    .DONE_LATENCY(3),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pt_shares(pt_shares),
    .key_shares(key_shares),
    .core_start(core_start),
    .core_pt(core_pt),
    .core_key(core_key),
    .core_done(core_done),
    .core_ct(core_ct),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ct_shares(ct_shares),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected ciphertext shares for a given operand pair (also used by the stub).
  function automatic logic [PW-1:0] model(input logic [PW-1:0] p,
                                          input logic [KW-1:0] k);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < SH; i++) begin
      r[i*64 +: 64] = p[i*64 +: 64] ^ k[i*128 +: 64];
    end
    r[63:0] = r[63:0] ^ KAT;
    return r;
  endfunction

  function automatic logic [63:0] xor_sh(input logic [PW-1:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < SH; i++) r = r ^ v[i*64 +: 64];
    return r;
  endfunction

  // Core stub: done rises in RUN cycle 46, optional early glitch.
  logic [7:0] s_cnt;
  logic       s_tie0;
  logic       s_glitch;

  always @(posedge clk) begin
    if (core_start) s_cnt <= '0;
    else if (s_cnt != 8'hff) s_cnt <= s_cnt + 8'd1;
  end

  always_comb begin
    core_done = 1'b0;
    if (!s_tie0 && !core_start) begin
      core_done = (s_cnt >= 8'd45) ||
                  (s_glitch && (s_cnt == 8'd9 || s_cnt == 8'd10));
    end
  end

  always_comb begin
    core_ct = model(core_pt, core_key);
    if (!core_done) core_ct = ~core_ct;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [KW-1:0] act,
                     input logic [KW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [PW-1:0] pt;
    logic [KW-1:0] key;
    bit            glitch;
    int            hold;
    bit            kat;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t          tbl[5];
  logic [PW-1:0] sb_q[$];

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [PW-1:0] zsh64();
    logic [63:0] a, b;
    a = r64();
    b = r64();
    return {a ^ b, b, a};
  endfunction

  function automatic logic [KW-1:0] zsh128();
    logic [127:0] a, b;
    a = {r64(), r64()};
    b = {r64(), r64()};
    return {a ^ b, b, a};
  endfunction

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk(name, 0, 1);
  endtask

  // Starts and ends just after a falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    int            t0;
    bit            seen;
    bit            bad;
    logic [PW-1:0] ct0;
    logic [PW-1:0] e;
    wait_ready({tag, "_ready_to"});
    in_valid   = 1'b1;
    pt_shares  = v.pt;
    key_shares = v.key;
    s_glitch   = v.glitch;
    @(posedge clk);
    #1;
    t0 = cyc;
    sb_q.push_back(v.exp);
    in_valid   = 1'b0;
    pt_shares  = ~v.pt;
    key_shares = ~v.key;
    @(negedge clk);
    chk({tag, "_load_rdy"}, in_ready, 0);
    chk({tag, "_load_busy"}, busy, 1);
    chk({tag, "_load_start"}, core_start, 1);
    chk({tag, "_load_pt"}, core_pt, v.pt);
    chk({tag, "_load_err"}, err, 0);
    seen = 1'b0;
    bad  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (core_key !== v.key || in_ready || core_start) bad = 1'b1;
    end
    chk({tag, "_run_key_stable"}, bad, 0);
    if (!seen) begin
      chk({tag, "_out_valid_to"}, 0, 1);
      return;
    end
    chk({tag, "_latency"}, cyc - t0, LAT);
    ct0 = ct_shares;
    bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!out_valid || in_ready || ct_shares !== ct0) bad = 1'b1;
    end
    if (v.hold > 0) chk({tag, "_backpressure"}, bad, 0);
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    chk({tag, "_ct_shares"}, ct_shares, e);
    if (v.kat) chk({tag, "_ct_xor"}, xor_sh(ct_shares), KAT);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, in_ready, 1);
    chk({tag, "_idle_ov"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    bit  ov_seen;
    bit  back;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    pt_shares  = '0;
    key_shares = '0;
    s_tie0     = 1'b0;
    s_glitch   = 1'b0;

    tbl[0] = '{pt: '0, key: '0, glitch: 0, hold: 0, kat: 1, exp: '0};
    tbl[1] = '{pt: zsh64(), key: zsh128(), glitch: 0, hold: 0,
               kat: 1, exp: '0};
    tbl[2] = '{pt: zsh64(), key: zsh128(), glitch: 0, hold: 20,
               kat: 1, exp: '0};
    tbl[3] = '{pt: '0, key: '0, glitch: 1, hold: 0, kat: 1, exp: '0};
    tbl[4] = '{pt: {r64(), r64(), r64()},
               key: {r64(), r64(), r64(), r64(), r64(), r64()},
               glitch: 0, hold: 3, kat: 0, exp: '0};
    for (int i = 0; i < 5; i++) tbl[i].exp = model(tbl[i].pt, tbl[i].key);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_core_start", core_start, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_core_pt", core_pt, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_ct", ct_shares, 0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Abort path: done never rises.
    s_tie0 = 1'b1;
    wait_ready("tmo_ready_to");
    in_valid   = 1'b1;
    pt_shares  = tbl[4].pt;
    key_shares = tbl[4].key;
    @(posedge clk);
    #1;
    t0 = cyc;
    in_valid = 1'b0;
    ov_seen  = 1'b0;
    back     = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
      if (in_ready) begin
        back = 1'b1;
        break;
      end
    end
    chk("tmo_back_idle", back, 1);
    chk("tmo_cycles", cyc - t0, TMO + 1);
    chk("tmo_err", err, 1);
    chk("tmo_no_out_valid", ov_seen, 0);
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", err, 1);
    s_tie0 = 1'b0;
    run_vec(tbl[1], "after_tmo");

    // Reset in RUN cycle 20 drops the operation.
    wait_ready("rst_ready_to");
    in_valid   = 1'b1;
    pt_shares  = tbl[4].pt;
    key_shares = tbl[4].key;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (21) @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_start", core_start, 1);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy_lo", busy, 0);
    chk("rst_mid_pt", core_pt, 0);
    run_vec(tbl[4], "after_rst");

    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
